// File: rtl/cva6_ldbuf_pkg.sv
// Shared types and sizing for the load-buffer tracker slice.
// Contents: buffer geometry (NR_ENTRIES, TRANS_ID_W, XLEN), the derived
// index, offset and count widths, the per-slot entry record and the
// load-size encoding. Retune the slice by editing the constants here.
// Optional feature (in the tracker): CVA6_LDBUF_SAME_CYCLE_REUSE_EN.
package cva6_ldbuf_pkg;
  localparam int NR_ENTRIES = 2;                 // power of two, 2..8
  localparam int TRANS_ID_W = 2;
  localparam int XLEN       = 32;
  localparam int IDX_W      = (NR_ENTRIES > 1) ? $clog2(NR_ENTRIES) : 1;
  localparam int OFF_W      = $clog2(XLEN / 8);
  localparam int CNT_W      = $clog2(NR_ENTRIES) + 1;

  typedef enum logic [1:0] {LD_B = 2'd0, LD_H = 2'd1, LD_W = 2'd2} ld_size_e;

  typedef struct packed {
    logic                  valid;
    logic                  killed;
    logic [TRANS_ID_W-1:0] trans_id;
    logic [OFF_W-1:0]      offset;
    logic [1:0]            size;
    logic                  sign;
  } ldbuf_entry_t;
endpackage

// File: rtl/cva6_ld_align.sv
// Combinational load alignment: shift the raw word right by offset bytes,
// keep byte/half/word, then sign- or zero-extend to XLEN. Size 3 acts as
// word. Also usable by the store-to-load forwarding path.
// Ports: data_i raw word, offset_i byte offset, size_i ld_size_e encoding,
//        sign_i sign-extend, data_o aligned result.
module cva6_ld_align
  import cva6_ldbuf_pkg::*;
(
  input  logic [XLEN-1:0]  data_i,
  input  logic [OFF_W-1:0] offset_i,
  input  logic [1:0]       size_i,
  input  logic             sign_i,
  output logic [XLEN-1:0]  data_o
);
  logic [XLEN-1:0] w_sh;

  assign w_sh = data_i >> {offset_i, 3'b000};

  always_comb begin
    data_o = '0;
    unique case (ld_size_e'(size_i))
      LD_B: begin
        data_o      = {XLEN{sign_i & w_sh[7]}};
        data_o[7:0] = w_sh[7:0];
      end
      LD_H: begin
        data_o       = {XLEN{sign_i & w_sh[15]}};
        data_o[15:0] = w_sh[15:0];
      end
      default: begin
        data_o       = {XLEN{sign_i & w_sh[31]}};
        data_o[31:0] = w_sh[31:0];
      end
    endcase
  end
endmodule

// File: rtl/cva6_ldbuf_tracker.sv
// Load-buffer tracker between the load unit and the dcache read port.
// Each issued load gets the lowest free slot (slot index = cache tid); the
// slot holds trans_id and alignment metadata until the response returns,
// then a registered, aligned writeback pulses for one cycle. A flush marks
// outstanding slots killed: they stay occupied until their response lands
// (the cache cannot cancel) and are then freed without writeback.
// Macro CVA6_LDBUF_SAME_CYCLE_REUSE_EN: when full, the slot being answered
// this cycle may be re-allocated on the same edge.
// Ports: clk_i/rst_ni clock and async active-low reset; alloc_* slot
// request and grant; rsp_* cache response; flush_i kill outstanding;
// wb_* writeback; count_o/empty_o occupancy.
module cva6_ldbuf_tracker
  import cva6_ldbuf_pkg::*;
(
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  alloc_valid_i,
  output logic                  alloc_ready_o,
  input  logic [TRANS_ID_W-1:0] alloc_trans_id_i,
  input  logic [OFF_W-1:0]      alloc_offset_i,
  input  logic [1:0]            alloc_size_i,
  input  logic                  alloc_sign_i,
  output logic [IDX_W-1:0]      alloc_idx_o,
  input  logic                  rsp_valid_i,
  input  logic [IDX_W-1:0]      rsp_idx_i,
  input  logic [XLEN-1:0]       rsp_data_i,
  input  logic                  flush_i,
  output logic                  wb_valid_o,
  output logic [TRANS_ID_W-1:0] wb_trans_id_o,
  output logic [XLEN-1:0]       wb_data_o,
  output logic [CNT_W-1:0]      count_o,
  output logic                  empty_o
);
  ldbuf_entry_t          r_ent [NR_ENTRIES];
  logic                  r_wb_valid;
  logic [TRANS_ID_W-1:0] r_wb_tid;
  logic [XLEN-1:0]       r_wb_data;
  logic [CNT_W-1:0]      r_count;

  logic                  w_any_free, w_rsp_hit, w_alloc;
  logic [IDX_W-1:0]      w_free_idx;
  ldbuf_entry_t          w_rsp_ent;
  logic [XLEN-1:0]       w_aligned;

  // Lowest-index free slot: scan high to low so the last hit wins.
  always_comb begin
    w_any_free = 1'b0;
    w_free_idx = '0;
    for (int i = NR_ENTRIES - 1; i >= 0; i--) begin
      if (!r_ent[i].valid) begin
        w_any_free = 1'b1;
        w_free_idx = IDX_W'(i);
      end
    end
  end

  assign w_rsp_ent = r_ent[rsp_idx_i];
  assign w_rsp_hit = rsp_valid_i & w_rsp_ent.valid;

  always_comb begin
`ifdef CVA6_LDBUF_SAME_CYCLE_REUSE_EN
    // Full buffer: hand the slot being answered straight back out.
    alloc_ready_o = (w_any_free | w_rsp_hit) & ~flush_i;
    alloc_idx_o   = w_any_free ? w_free_idx : rsp_idx_i;
`else
    alloc_ready_o = w_any_free & ~flush_i;
    alloc_idx_o   = w_free_idx;
`endif
  end

  assign w_alloc = alloc_valid_i & alloc_ready_o;

  cva6_ld_align u_align (
    .data_i   (rsp_data_i),
    .offset_i (w_rsp_ent.offset),
    .size_i   (w_rsp_ent.size),
    .sign_i   (w_rsp_ent.sign),
    .data_o   (w_aligned)
  );

  // Free-on-response is written before allocate so a same-edge reuse of
  // the answered slot takes the new metadata.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < NR_ENTRIES; i++) r_ent[i] <= '0;
    end else begin
      for (int i = 0; i < NR_ENTRIES; i++) begin
        if (w_rsp_hit && rsp_idx_i == IDX_W'(i)) begin
          r_ent[i].valid  <= 1'b0;
          r_ent[i].killed <= 1'b0;
        end else if (flush_i && r_ent[i].valid) begin
          r_ent[i].killed <= 1'b1;
        end
        if (w_alloc && alloc_idx_o == IDX_W'(i)) begin
          r_ent[i].valid    <= 1'b1;
          r_ent[i].killed   <= 1'b0;
          r_ent[i].trans_id <= alloc_trans_id_i;
          r_ent[i].offset   <= alloc_offset_i;
          r_ent[i].size     <= alloc_size_i;
          r_ent[i].sign     <= alloc_sign_i;
        end
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_wb_valid <= 1'b0;
      r_wb_tid   <= '0;
      r_wb_data  <= '0;
      r_count    <= '0;
    end else begin
      r_wb_valid <= w_rsp_hit & ~w_rsp_ent.killed;
      if (w_rsp_hit && !w_rsp_ent.killed) begin
        r_wb_tid  <= w_rsp_ent.trans_id;
        r_wb_data <= w_aligned;
      end
      r_count <= r_count + CNT_W'(w_alloc) - CNT_W'(w_rsp_hit);
    end
  end

`ifndef SYNTHESIS
  // A response to an unallocated slot is dropped; warn so it is visible.
  always @(posedge clk_i) begin
    if (rst_ni && rsp_valid_i)
      assert (w_rsp_ent.valid) else $warning("ldbuf: response to unallocated slot %0d ignored", rsp_idx_i);
  end
`endif

  assign wb_valid_o    = r_wb_valid;
  assign wb_trans_id_o = r_wb_tid;
  assign wb_data_o     = r_wb_data;
  assign count_o       = r_count;
  assign empty_o       = (r_count == '0);
endmodule

// File: tb/tb_cva6_ldbuf_tracker.sv
module tb_cva6_ldbuf_tracker;
  logic        clk_i = 1'b0, rst_ni = 1'b0;
  logic        alloc_valid_i = 1'b0, alloc_sign_i = 1'b0;
  logic        alloc_ready_o;
  logic [1:0]  alloc_trans_id_i = '0, alloc_offset_i = '0, alloc_size_i = '0;
  logic        alloc_idx_o;
  logic        rsp_valid_i = 1'b0, rsp_idx_i = 1'b0;
  logic [31:0] rsp_data_i = '0;
  logic        flush_i = 1'b0;
  logic        wb_valid_o;
  logic [1:0]  wb_trans_id_o;
  logic [31:0] wb_data_o;
  logic [1:0]  count_o;
  logic        empty_o;

  cva6_ldbuf_tracker dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .alloc_valid_i(alloc_valid_i), .alloc_ready_o(alloc_ready_o),
    .alloc_trans_id_i(alloc_trans_id_i), .alloc_offset_i(alloc_offset_i),
    .alloc_size_i(alloc_size_i), .alloc_sign_i(alloc_sign_i),
    .alloc_idx_o(alloc_idx_o),
    .rsp_valid_i(rsp_valid_i), .rsp_idx_i(rsp_idx_i), .rsp_data_i(rsp_data_i),
    .flush_i(flush_i),
    .wb_valid_o(wb_valid_o), .wb_trans_id_o(wb_trans_id_o), .wb_data_o(wb_data_o),
    .count_o(count_o), .empty_o(empty_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic [1:0]  tid;
    logic [31:0] data;
    int          cyc;
  } exp_t;

  exp_t q[$];
  int   total = 0, bad = 0, cyc = 0;

  always @(posedge clk_i) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s act=%h exp=%h", nm, act, exp);
    end
  endtask

  // Monitor: every writeback must match the oldest expectation, arriving
  // exactly one cycle after its response was driven.
  always @(negedge clk_i) begin
    if (rst_ni && wb_valid_o) begin
      total++;
      if (q.size() == 0) begin
        bad++;
        $display("FAIL wb_unexpected act tid=%0d data=%h exp none", wb_trans_id_o, wb_data_o);
      end else begin
        exp_t e;
        e = q.pop_front();
        if (wb_trans_id_o !== e.tid || wb_data_o !== e.data || cyc != e.cyc) begin
          bad++;
          $display("FAIL wb act tid=%0d data=%h cyc=%0d exp tid=%0d data=%h cyc=%0d",
                   wb_trans_id_o, wb_data_o, cyc, e.tid, e.data, e.cyc);
        end
      end
    end
  end

  // Drivers: called right after a negedge; return on the next negedge.
  task automatic do_alloc(input logic [1:0] tid, input logic [1:0] off,
                          input logic [1:0] sz, input logic sg);
    alloc_valid_i = 1'b1; alloc_trans_id_i = tid; alloc_offset_i = off;
    alloc_size_i = sz; alloc_sign_i = sg;
    @(negedge clk_i);
    alloc_valid_i = 1'b0;
  endtask

  task automatic do_rsp(input logic idx, input logic [31:0] d, input logic wb,
                        input logic [1:0] tid, input logic [31:0] exp_d);
    exp_t e;
    rsp_valid_i = 1'b1; rsp_idx_i = idx; rsp_data_i = d;
    if (wb) begin
      e.tid = tid; e.data = exp_d; e.cyc = cyc + 1;
      q.push_back(e);
    end
    @(negedge clk_i);
    rsp_valid_i = 1'b0;
  endtask

  initial begin
    repeat (3) @(negedge clk_i);
    chk("rst_wb_valid", 32'(wb_valid_o), 32'd0);
    chk("rst_wb_tid",   32'(wb_trans_id_o), 32'd0);
    chk("rst_wb_data",  wb_data_o, 32'd0);
    chk("rst_count",    32'(count_o), 32'd0);
    chk("rst_empty",    32'(empty_o), 32'd1);
    chk("rst_ready",    32'(alloc_ready_o), 32'd1);
    rst_ni = 1'b1;
    @(negedge clk_i);

    // Signed byte at offset 1
    chk("t1_idx", 32'(alloc_idx_o), 32'd0);
    do_alloc(2'd3, 2'd1, 2'd0, 1'b1);
    chk("t1_count", 32'(count_o), 32'd1);
    chk("t1_empty", 32'(empty_o), 32'd0);
    do_rsp(1'b0, 32'h0000_8000, 1'b1, 2'd3, 32'hFFFF_FF80);
    @(negedge clk_i);
    chk("t1_hold_valid", 32'(wb_valid_o), 32'd0);
    chk("t1_hold_data", wb_data_o, 32'hFFFF_FF80);
    chk("t1_count0", 32'(count_o), 32'd0);

    // Fill, blocked third alloc, free slot 1
    do_alloc(2'd0, 2'd0, 2'd2, 1'b0);
    chk("t2_idx1", 32'(alloc_idx_o), 32'd1);
    do_alloc(2'd1, 2'd0, 2'd2, 1'b0);
    chk("t2_ready_full", 32'(alloc_ready_o), 32'd0);
    chk("t2_count2", 32'(count_o), 32'd2);
    alloc_valid_i = 1'b1; alloc_trans_id_i = 2'd2;
    #1 chk("t2_ready_req", 32'(alloc_ready_o), 32'd0);
    @(negedge clk_i);
    alloc_valid_i = 1'b0;
    chk("t2_count_blocked", 32'(count_o), 32'd2);
    do_rsp(1'b1, 32'h1122_3344, 1'b1, 2'd1, 32'h1122_3344);
    chk("t2_idx_after", 32'(alloc_idx_o), 32'd1);
    chk("t2_count1", 32'(count_o), 32'd1);
    chk("t2_ready1", 32'(alloc_ready_o), 32'd1);
    do_rsp(1'b0, 32'hCAFE_F00D, 1'b1, 2'd0, 32'hCAFE_F00D);
    chk("t2_count0", 32'(count_o), 32'd0);

    // Flush kills both outstanding loads
    do_alloc(2'd2, 2'd0, 2'd2, 1'b0);
    do_alloc(2'd3, 2'd0, 2'd2, 1'b0);
    flush_i = 1'b1;
    #1 chk("t3_ready_flush", 32'(alloc_ready_o), 32'd0);
    @(negedge clk_i);
    flush_i = 1'b0;
    chk("t3_count_kept", 32'(count_o), 32'd2);
    do_rsp(1'b0, 32'h1111_1111, 1'b0, 2'd0, 32'd0);
    do_rsp(1'b1, 32'h2222_2222, 1'b0, 2'd0, 32'd0);
    @(negedge clk_i);
    chk("t3_count0", 32'(count_o), 32'd0);
    chk("t3_empty", 32'(empty_o), 32'd1);

    // Full with simultaneous alloc and response to slot 0
    do_alloc(2'd0, 2'd0, 2'd2, 1'b0);
    do_alloc(2'd1, 2'd0, 2'd2, 1'b0);
    alloc_valid_i = 1'b1; alloc_trans_id_i = 2'd2; alloc_offset_i = 2'd0;
    alloc_size_i = 2'd2; alloc_sign_i = 1'b0;
`ifdef CVA6_LDBUF_SAME_CYCLE_REUSE_EN
    rsp_valid_i = 1'b1; rsp_idx_i = 1'b0;
    #1 chk("t4_reuse_ready", 32'(alloc_ready_o), 32'd1);
    chk("t4_reuse_idx", 32'(alloc_idx_o), 32'd0);
    rsp_valid_i = 1'b0;
    do_rsp(1'b0, 32'h0A0B_0C0D, 1'b1, 2'd0, 32'h0A0B_0C0D);
    alloc_valid_i = 1'b0;
    chk("t4_reuse_count", 32'(count_o), 32'd2);
    do_rsp(1'b0, 32'h5555_6666, 1'b1, 2'd2, 32'h5555_6666);
`else
    rsp_valid_i = 1'b1; rsp_idx_i = 1'b0;
    #1 chk("t4_noreuse_ready", 32'(alloc_ready_o), 32'd0);
    rsp_valid_i = 1'b0;
    do_rsp(1'b0, 32'h0A0B_0C0D, 1'b1, 2'd0, 32'h0A0B_0C0D);
    alloc_valid_i = 1'b0;
    chk("t4_noreuse_count", 32'(count_o), 32'd1);
    chk("t4_noreuse_idx", 32'(alloc_idx_o), 32'd0);
`endif
    do_rsp(1'b1, 32'h7777_8888, 1'b1, 2'd1, 32'h7777_8888);
    chk("t4_count0", 32'(count_o), 32'd0);

    // Alignment patterns
    do_alloc(2'd1, 2'd2, 2'd1, 1'b0);
    do_rsp(1'b0, 32'hBEEF_1234, 1'b1, 2'd1, 32'h0000_BEEF);
    do_alloc(2'd2, 2'd0, 2'd2, 1'b1);
    do_rsp(1'b0, 32'hBEEF_1234, 1'b1, 2'd2, 32'hBEEF_1234);
    do_alloc(2'd3, 2'd0, 2'd1, 1'b1);
    do_rsp(1'b0, 32'h0000_8001, 1'b1, 2'd3, 32'hFFFF_8001);
    do_alloc(2'd0, 2'd3, 2'd0, 1'b0);
    do_rsp(1'b0, 32'hF000_0000, 1'b1, 2'd0, 32'h0000_00F0);
    do_alloc(2'd1, 2'd0, 2'd3, 1'b1);
    do_rsp(1'b0, 32'h8000_0001, 1'b1, 2'd1, 32'h8000_0001);
    @(negedge clk_i);

    // Reset with both slots valid, then a stale response
    do_alloc(2'd2, 2'd0, 2'd2, 1'b0);
    do_alloc(2'd3, 2'd0, 2'd2, 1'b0);
    rst_ni = 1'b0;
    #1 chk("t6_rst_count", 32'(count_o), 32'd0);
    chk("t6_rst_wbdata", wb_data_o, 32'd0);
    @(negedge clk_i);
    rst_ni = 1'b1;
    @(negedge clk_i);
    do_rsp(1'b0, 32'hDEAD_BEEF, 1'b0, 2'd0, 32'd0);
    @(negedge clk_i);
    chk("t6_count", 32'(count_o), 32'd0);
    chk("t6_empty", 32'(empty_o), 32'd1);

    repeat (3) @(negedge clk_i);
    chk("sb_drained", 32'(q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout act=running exp=finished");
    $fatal(1, "timeout");
  end
endmodule
